if_prefetch: RTL and testbench
==============================

// Module: if_prefetch
// PURPOSE
//  Parametrised instruction-fetch stage with a prefetch queue. Issues PC-ordered
//  requests to a synchronous instruction memory, buffers {PC, instruction} pairs,
//  and hands them to ID over a valid/ready handshake. Branch redirects flush all
//  queued and in-flight fetches. Sits between the PC/branch logic and the IF/ID boundary.
// PARAMETERS
//  XLEN        32   PC and instruction width.
//  IMEM_AW     10   Word-address width to instruction memory (byte PC bits [IMEM_AW+1:2]).
//  RESET_PC    0    PC value loaded on reset (XLEN bits, low 2 bits 0).
//  DEPTH       2    Prefetch queue entries (>=2, any integer).
// PORTS
//  clk             in   1        Clock, all state on rising edge.
//  reset           in   1        Synchronous, active-high reset.
//  PCSrc           in   1        Redirect request; PC_Branch valid this cycle.
//  PC_Branch       in   XLEN     Redirect target; bits [1:0] ignored (forced 0).
//  PC_write        in   1        Fetch enable; 0 = issue no new requests (stall).
//  imem_req        out  1        Instruction-memory read request this cycle.
//  imem_addr       out  IMEM_AW  Word address of request.
//  imem_rdata      in   XLEN     Read data, valid exactly 1 cycle after imem_req.
//  instr_valid     out  1        Queue head holds a valid instruction.
//  instr_ready     in   1        ID accepts head when instr_valid & instr_ready.
//  PC_IF           out  XLEN     PC of queue head.
//  INSTRUCTION_IF  out  XLEN     Instruction at queue head.
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC; queue count=0; inflight=0; instr_valid=0,
//   imem_req=0, PC_IF=0, INSTRUCTION_IF=0. First request issued on the first cycle
//   with reset low. Reset asserted mid-operation discards all queued/in-flight data.
//  State: fetch_pc (next PC to request), inflight flag + inflight_pc (one-deep,
//   since memory latency is 1), circular queue of DEPTH {pc,instr} with rd/wr ptrs, count.
//  pop = instr_valid & instr_ready & ~PCSrc.
//  Issue rule (no redirect): imem_req = PC_write & (count + inflight - pop < DEPTH);
//   imem_addr = fetch_pc[IMEM_AW+1:2]; on issue fetch_pc <= fetch_pc+4,
//   inflight<=1, inflight_pc<=fetch_pc; else inflight<=0.
//  Response: when inflight=1 and not killed, push {inflight_pc, imem_rdata} into queue
//   at that cycle's edge. Latency: request in cycle N -> instr_valid in cycle N+2.
//  Push and pop in the same cycle: count unchanged, both pointers advance.
//  Full: issue rule guarantees no push when full; overflow is a design error (assert).
//  Empty: instr_valid=0; PC_IF/INSTRUCTION_IF hold last head contents (don't-care).
//  Redirect (PCSrc=1, highest priority after reset):
//   - instr_valid forced 0 this cycle (no handshake with ID);
//   - queue cleared (count=0, ptrs=0); current in-flight response discarded;
//   - if PC_write=1, request issued same cycle at PC_Branch: imem_addr=
//     PC_Branch[IMEM_AW+1:2], fetch_pc<=tgt+4, inflight_pc<=tgt (tgt=PC_Branch&~3);
//   - if PC_write=0, fetch_pc<=tgt, no request, inflight<=0.
//  PC_write=0 without redirect: no new request; in-flight response still pushed;
//   queue keeps draining to ID.
//  Arithmetic: fetch_pc+4 wraps modulo 2^XLEN (0xFFFFFFFC -> 0x00000000 at XLEN=32).
//   imem_addr truncates PC; aliasing above 2^(IMEM_AW+2) bytes is accepted.
//  Throughput: with instr_ready=1 and PC_write=1, one instruction per cycle sustained
//   for DEPTH>=2.
// TESTING
//  1 Reset release, RESET_PC=0, instr_ready=1, mem[i]=0x100+i -> PC_IF 0,4,8,...
//    from cycle 2 after reset, INSTRUCTION_IF 0x100,0x101,..., instr_valid held high.
//  2 instr_ready=0 for 6 cycles -> exactly DEPTH entries queued, imem_req=0 after
//    fill; on ready=1, PCs continue contiguously, no loss or duplicate.
//  3 PCSrc=1, PC_Branch=0x40 while queue full + in-flight -> instr_valid=0 that
//    cycle, imem_addr=0x10; next valid PC_IF=0x40, then 0x44; no stale PC appears.
//  4 PC_Branch=0x43 -> treated as 0x40; PC_write=0 with PCSrc=1 -> no request until
//    PC_write=1, then first fetch at 0x40.
//  5 Redirect to 0xFFFFFFF8 -> PC_IF sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
//  6 reset=1 for 1 cycle mid-stream with queue non-empty -> instr_valid=0 next cycle,
//    outputs zero, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: issues PC-ordered requests to a 1-cycle synchronous
// instruction memory and buffers {pc, instr} pairs in a DEPTH-entry queue for ID.
module if_prefetch #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     IMEM_AW  = 10,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PCSrc,
    input  logic [XLEN-1:0]    PC_Branch,
    input  logic               PC_write,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [XLEN-1:0]    PC_IF,
    output logic [XLEN-1:0]    INSTRUCTION_IF
);
    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_X  = (CNT_W + 1)'(DEPTH);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
    logic [XLEN-1:0]  pc_mem_q [DEPTH];
    logic [XLEN-1:0]  pc_mem_d [DEPTH];
    logic [XLEN-1:0]  instr_mem_q [DEPTH];
    logic [XLEN-1:0]  instr_mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [XLEN-1:0]  tgt_pc;
    logic [XLEN-1:0]  issue_pc;
    logic [CNT_W:0]   occupancy;
    logic             room;
    logic             push;
    logic             pop;
    logic             unused_branch_lsbs;

    assign unused_branch_lsbs = ^PC_Branch[1:0];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // ID handshake: the head transfers on a cycle where instr_valid & instr_ready;
    // instr_valid never depends on instr_ready, and a redirect or reset suppresses it.
    always_comb begin
        tgt_pc      = {PC_Branch[XLEN-1:2], 2'b00};
        instr_valid = ~reset & ~PCSrc & (count_q != '0);
        pop         = instr_valid & instr_ready;
        push        = ~reset & ~PCSrc & inflight_q;
        occupancy   = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        room        = occupancy < (DEPTH_X + {{CNT_W{1'b0}}, pop});
        issue_pc    = PCSrc ? tgt_pc : fetch_pc_q;
        imem_req    = ~reset & PC_write & (PCSrc | room);
        imem_addr   = issue_pc[IMEM_AW+1:2];
    end

    assign PC_IF          = pc_mem_q[rd_ptr_q];
    assign INSTRUCTION_IF = instr_mem_q[rd_ptr_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (PCSrc) begin
            fetch_pc_d = PC_write ? tgt_pc + XLEN'(4) : tgt_pc;
        end else if (imem_req) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        inflight_d    = imem_req;
        inflight_pc_d = imem_req ? issue_pc : inflight_pc_q;
    end

    // A redirect drops queued entries and the response returning this cycle.
    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        if (PCSrc) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]    = inflight_pc_q;
                instr_mem_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d              = next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            pc_mem_q      <= '{default: '0};
            instr_mem_q   <= '{default: '0};
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            pc_mem_q      <= pc_mem_d;
            instr_mem_q   <= instr_mem_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && !pop && count_q == CNT_W'(DEPTH)))
            else $error("if_prefetch: push into full prefetch queue");
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: the memory returns 0x100 + word address and a
// scoreboard checks each accepted {PC_IF, INSTRUCTION_IF} against the expected stream.
module tb_if_prefetch;
    logic        clk;
    logic        reset;
    logic        PCSrc;
    logic [31:0] PC_Branch;
    logic        PC_write;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] PC_IF;
    logic [31:0] INSTRUCTION_IF;

    logic [63:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          pops     = 0;
    int          pops_base;

    if_prefetch #(
        .XLEN(32), .IMEM_AW(10), .RESET_PC(32'h0), .DEPTH(2)
    ) dut (
        .clk(clk), .reset(reset), .PCSrc(PCSrc), .PC_Branch(PC_Branch),
        .PC_write(PC_write), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .PC_IF(PC_IF), .INSTRUCTION_IF(INSTRUCTION_IF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= 32'h100 + {22'b0, imem_addr};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        logic [31:0] pc;
        for (int i = 0; i < n; i++) begin
            pc = base + 32'(4 * i);
            exp_q.push_back({pc, 32'h100 + {22'b0, pc[11:2]}});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Scoreboard: every handshake with ID pops one expected {pc, instr}.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!reset && !PCSrc && instr_valid && instr_ready) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
            chk("pc_if", PC_IF, e[63:32]);
            chk("instr_if", INSTRUCTION_IF, e[31:0]);
            pops++;
        end
    end

    initial begin
        reset       = 1'b1;
        PCSrc       = 1'b0;
        PC_Branch   = 32'h0;
        PC_write    = 1'b1;
        instr_ready = 1'b1;
        imem_rdata  = 32'h0;
        repeat (3) tick();
        neg();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pc_if", PC_IF, 32'h0);
        chk("rst_instr_if", INSTRUCTION_IF, 32'h0);

        // Test 1: reset release, streaming from RESET_PC
        tick();
        push_seq(32'h0, 40);
        reset = 1'b0;
        neg();
        chk("t1_first_req", 32'(imem_req), 32'd1);
        chk("t1_first_addr", 32'(imem_addr), 32'h0);
        chk("t1_valid_c0", 32'(instr_valid), 32'd0);
        tick(); neg();
        chk("t1_valid_c1", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick(); neg();
            chk("t1_valid_stream", 32'(instr_valid), 32'd1);
        end

        // Test 2: ID stalls for 6 cycles, queue fills and fetch stops
        tick();
        instr_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) tick();
            neg();
            chk("t2_req_stalled", 32'(imem_req), 32'd0);
            chk("t2_valid_held", 32'(instr_valid), 32'd1);
        end
        tick();
        instr_ready = 1'b1;
        neg();
        chk("t2_req_resume", 32'(imem_req), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick(); neg();
            chk("t2_valid_resume", 32'(instr_valid), 32'd1);
        end

        // Test 3: redirect to 0x40 with occupancy full
        tick();
        exp_q.delete();
        push_seq(32'h40, 40);
        PCSrc     = 1'b1;
        PC_Branch = 32'h40;
        neg();
        chk("t3_valid_redirect", 32'(instr_valid), 32'd0);
        chk("t3_req_redirect", 32'(imem_req), 32'd1);
        chk("t3_addr_redirect", 32'(imem_addr), 32'h10);
        tick();
        PCSrc = 1'b0;
        neg();
        chk("t3_valid_after", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); neg();
            chk("t3_valid_stream", 32'(instr_valid), 32'd1);
        end

        // Test 4: unaligned target with fetch disabled
        tick();
        exp_q.delete();
        push_seq(32'h40, 40);
        PCSrc     = 1'b1;
        PC_Branch = 32'h43;
        PC_write  = 1'b0;
        neg();
        chk("t4_req_redirect", 32'(imem_req), 32'd0);
        chk("t4_valid_redirect", 32'(instr_valid), 32'd0);
        tick();
        PCSrc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) tick();
            neg();
            chk("t4_req_stalled", 32'(imem_req), 32'd0);
            chk("t4_valid_empty", 32'(instr_valid), 32'd0);
        end
        tick();
        PC_write = 1'b1;
        neg();
        chk("t4_req_enable", 32'(imem_req), 32'd1);
        chk("t4_addr_enable", 32'(imem_addr), 32'h10);
        tick(); neg();
        chk("t4_valid_c1", 32'(instr_valid), 32'd0);
        tick(); neg();
        chk("t4_valid_c2", 32'(instr_valid), 32'd1);

        // Test 5: redirect near the top of the address space, PC wraps to 0
        tick();
        exp_q.delete();
        push_seq(32'hFFFF_FFF8, 40);
        pops_base = pops;
        PCSrc     = 1'b1;
        PC_Branch = 32'hFFFF_FFF8;
        neg();
        chk("t5_req_redirect", 32'(imem_req), 32'd1);
        chk("t5_addr_redirect", 32'(imem_addr), 32'h3FE);
        tick();
        PCSrc = 1'b0;
        neg();
        chk("t5_valid_c1", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(); neg();
            chk("t5_valid_stream", 32'(instr_valid), 32'd1);
        end
        tick();
        chk("t5_accept_count", 32'(pops - pops_base), 32'd4);

        // Test 6: one-cycle reset mid-stream with a non-empty queue
        instr_ready = 1'b0;
        tick();
        tick();
        exp_q.delete();
        push_seq(32'h0, 40);
        pops_base   = pops;
        reset       = 1'b1;
        instr_ready = 1'b1;
        neg();
        chk("t6_valid_in_reset", 32'(instr_valid), 32'd0);
        chk("t6_req_in_reset", 32'(imem_req), 32'd0);
        tick();
        reset = 1'b0;
        neg();
        chk("t6_valid_after", 32'(instr_valid), 32'd0);
        chk("t6_pc_if_zero", PC_IF, 32'h0);
        chk("t6_instr_if_zero", INSTRUCTION_IF, 32'h0);
        chk("t6_req_restart", 32'(imem_req), 32'd1);
        chk("t6_addr_restart", 32'(imem_addr), 32'h0);
        tick(); neg();
        chk("t6_valid_c1", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick(); neg();
            chk("t6_valid_stream", 32'(instr_valid), 32'd1);
        end
        tick();
        chk("t6_accept_count", 32'(pops - pops_base), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
